// File: rtl/io_bridge_if.sv
// CPU data-port / peripheral-port bundle of the memory-mapped I/O bridge.
// The bridge takes the slave view; the CPU/peripheral side takes the master view.
interface io_bridge_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IO_W   = 16;

  logic [ADDR_W-1:0] Addr_in;
  logic              Mem_read;
  logic              Mem_write;
  logic [DATA_W-1:0] Wdata_in;
  logic [DATA_W-1:0] Mem_rdata;
  logic [IO_W-1:0]   Switch_rdata;

  logic              Mem_we;
  logic [DATA_W-1:0] Rdata_out;
  logic              Stall;
  logic              LED_select;
  logic              Switch_select;
  logic              IO_write_enable;
  logic [1:0]        IO_address;
  logic [IO_W-1:0]   IO_wdata;
  logic              Bus_error;
  logic [ADDR_W-1:0] Err_addr;

  modport master (
    output Addr_in, Mem_read, Mem_write, Wdata_in, Mem_rdata, Switch_rdata,
    input  Mem_we, Rdata_out, Stall, LED_select, Switch_select,
           IO_write_enable, IO_address, IO_wdata, Bus_error, Err_addr
  );

  modport slave (
    input  Addr_in, Mem_read, Mem_write, Wdata_in, Mem_rdata, Switch_rdata,
    output Mem_we, Rdata_out, Stall, LED_select, Switch_select,
           IO_write_enable, IO_address, IO_wdata, Bus_error, Err_addr
  );
endinterface

// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge: RAM accesses pass straight through, I/O accesses
// run a stalled three-state bus cycle (IDLE -> ACCESS -> DONE) to LED/switch blocks.
module io_bridge (
  input  logic       clock,
  input  logic       reset,
  io_bridge_if.slave bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IO_W   = 16;
  localparam int unsigned BASE_W = 22;
  localparam int unsigned OFF_W  = 10;

  localparam logic [BASE_W-1:0] IO_BASE    = 22'h3FFFFF;
  localparam logic [OFF_W-1:0]  LED_OFFSET = 10'h060;
  localparam logic [OFF_W-1:0]  SW_OFFSET  = 10'h070;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [IO_W-1:0]   wdata;
    logic              sw_rd;
    logic              illegal;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q, req_d;

  logic              led_sel_q, led_sel_d;
  logic              sw_sel_q, sw_sel_d;
  logic              io_we_q, io_we_d;
  logic [1:0]        io_addr_q, io_addr_d;
  logic [IO_W-1:0]   io_wdata_q, io_wdata_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic              stall_c;
  logic [DATA_W-1:0] rdata_c;

  logic io_hit, req_rd_only, req_wr_only, at_led, at_sw, led_wr, sw_rd;
  logic unused_wdata_hi;

  // Region and offset decode of the live CPU request
  assign io_hit      = (bus.Mem_read | bus.Mem_write) &
                       (bus.Addr_in[ADDR_W-1:OFF_W] == IO_BASE);
  assign req_rd_only = bus.Mem_read & ~bus.Mem_write;
  assign req_wr_only = bus.Mem_write & ~bus.Mem_read;
  assign at_led      = (bus.Addr_in[OFF_W-1:0] == LED_OFFSET) ||
                       (bus.Addr_in[OFF_W-1:0] == LED_OFFSET + OFF_W'(2));
  assign at_sw       = (bus.Addr_in[OFF_W-1:0] == SW_OFFSET) ||
                       (bus.Addr_in[OFF_W-1:0] == SW_OFFSET + OFF_W'(2));
  assign led_wr      = req_wr_only & at_led;
  assign sw_rd       = req_rd_only & at_sw;

  assign unused_wdata_hi = ^bus.Wdata_in[DATA_W-1:IO_W];

  // Next-state, next-register values and the combinational CPU-side outputs
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    led_sel_d  = 1'b0;
    sw_sel_d   = 1'b0;
    io_we_d    = 1'b0;
    io_addr_d  = 2'b00;
    io_wdata_d = '0;
    rd_d       = rd_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    stall_c    = 1'b0;
    rdata_c    = bus.Mem_rdata;

    case (state_q)
      IDLE: begin
        stall_c = io_hit;
        if (io_hit) begin
          req_d.addr    = bus.Addr_in;
          req_d.wdata   = bus.Wdata_in[IO_W-1:0];
          req_d.sw_rd   = sw_rd;
          req_d.illegal = ~(led_wr | sw_rd);
          led_sel_d     = led_wr;
          sw_sel_d      = sw_rd;
          io_we_d       = led_wr;
          io_addr_d     = bus.Addr_in[1:0];
          io_wdata_d    = bus.Wdata_in[IO_W-1:0];
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        rd_d    = req_q.sw_rd ? {(DATA_W-IO_W)'(0), bus.Switch_rdata} : '0;
        if (req_q.illegal) begin
          err_d = 1'b1;
          if (!err_q) err_addr_d = req_q.addr;
        end
        state_d = DONE;
      end
      DONE: begin
        // CPU still presents the finished instruction; ignore it for one cycle
        rdata_c = rd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= '0;
      led_sel_q  <= 1'b0;
      sw_sel_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= 2'b00;
      io_wdata_q <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      led_sel_q  <= led_sel_d;
      sw_sel_q   <= sw_sel_d;
      io_we_q    <= io_we_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.Mem_we          = bus.Mem_write & ~io_hit;
  assign bus.Stall           = stall_c;
  assign bus.Rdata_out       = rdata_c;
  assign bus.LED_select      = led_sel_q;
  assign bus.Switch_select   = sw_sel_q;
  assign bus.IO_write_enable = io_we_q;
  assign bus.IO_address      = io_addr_q;
  assign bus.IO_wdata        = io_wdata_q;
  assign bus.Bus_error       = err_q;
  assign bus.Err_addr        = err_addr_q;
endmodule

// File: tb/tb_io_bridge.sv
// Scenario bench for io_bridge: directed cases plus randomized accesses
// checked cycle by cycle against an access-level reference model.
module tb_io_bridge;
  logic clock = 1'b0;
  logic reset = 1'b0;

  io_bridge_if bus();

  io_bridge dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Sticky error state expected by the model
  logic        m_err   = 1'b0;
  logic [31:0] m_eaddr = 32'h0;

  // 0: not an I/O access, 1: legal LED write, 2: legal switch read, 3: illegal I/O
  function automatic int classify(input logic [31:0] a, input logic rd, input logic wr);
    int unsigned off;
    if (!(rd || wr) || a < 32'hFFFFFC00) return 0;
    off = a - 32'hFFFFFC00;
    if (wr && !rd && (off == 96 || off == 98)) return 1;
    if (rd && !wr && (off == 112 || off == 114)) return 2;
    return 3;
  endfunction

  task automatic drive(input logic [31:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd, input logic [31:0] md, input logic [15:0] sw);
    bus.Addr_in      = a;
    bus.Mem_read     = rd;
    bus.Mem_write    = wr;
    bus.Wdata_in     = wd;
    bus.Mem_rdata    = md;
    bus.Switch_rdata = sw;
    #1;
  endtask

  task automatic idle_in;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_in();
    step();
    step();
    n_cmp++; if (bus.LED_select !== 1'b0) begin n_fail++; $display("FAIL rst_led got %b exp 0", bus.LED_select); end
    n_cmp++; if (bus.Switch_select !== 1'b0) begin n_fail++; $display("FAIL rst_sw got %b exp 0", bus.Switch_select); end
    n_cmp++; if (bus.IO_write_enable !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", bus.IO_write_enable); end
    n_cmp++; if (bus.IO_address !== 2'b00) begin n_fail++; $display("FAIL rst_addr got %b exp 00", bus.IO_address); end
    n_cmp++; if (bus.IO_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_wdata got %h exp 0000", bus.IO_wdata); end
    n_cmp++; if (bus.Bus_error !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", bus.Bus_error); end
    n_cmp++; if (bus.Err_addr !== 32'h0) begin n_fail++; $display("FAIL rst_eaddr got %h exp 0", bus.Err_addr); end
    n_cmp++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b exp 0", bus.Stall); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_led_write;
    drive(32'hFFFFFC60, 1'b0, 1'b1, 32'h0000A55A, 32'h0, 16'h0);
    n_cmp++; if (bus.Stall !== 1'b1) begin n_fail++; $display("FAIL led_stall0 got %b exp 1", bus.Stall); end
    n_cmp++; if (bus.Mem_we !== 1'b0) begin n_fail++; $display("FAIL led_mwe0 got %b exp 0", bus.Mem_we); end
    n_cmp++; if (bus.LED_select !== 1'b0) begin n_fail++; $display("FAIL led_sel0 got %b exp 0", bus.LED_select); end
    step();
    n_cmp++; if (bus.Stall !== 1'b1) begin n_fail++; $display("FAIL led_stall1 got %b exp 1", bus.Stall); end
    n_cmp++; if (bus.LED_select !== 1'b1) begin n_fail++; $display("FAIL led_sel1 got %b exp 1", bus.LED_select); end
    n_cmp++; if (bus.IO_write_enable !== 1'b1) begin n_fail++; $display("FAIL led_we1 got %b exp 1", bus.IO_write_enable); end
    n_cmp++; if (bus.IO_address !== 2'b00) begin n_fail++; $display("FAIL led_addr1 got %b exp 00", bus.IO_address); end
    n_cmp++; if (bus.IO_wdata !== 16'hA55A) begin n_fail++; $display("FAIL led_wdata1 got %h exp a55a", bus.IO_wdata); end
    n_cmp++; if (bus.Mem_we !== 1'b0) begin n_fail++; $display("FAIL led_mwe1 got %b exp 0", bus.Mem_we); end
    step();
    n_cmp++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL led_stall2 got %b exp 0", bus.Stall); end
    n_cmp++; if (bus.LED_select !== 1'b0) begin n_fail++; $display("FAIL led_sel2 got %b exp 0", bus.LED_select); end
    n_cmp++; if (bus.Mem_we !== 1'b0) begin n_fail++; $display("FAIL led_mwe2 got %b exp 0", bus.Mem_we); end
    step();
    idle_in();
  endtask

  task automatic test_switch_read;
    drive(32'hFFFFFC72, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 16'h1234);
    n_cmp++; if (bus.Switch_select !== 1'b0) begin n_fail++; $display("FAIL sw_sel0 got %b exp 0", bus.Switch_select); end
    step();
    n_cmp++; if (bus.Switch_select !== 1'b1) begin n_fail++; $display("FAIL sw_sel1 got %b exp 1", bus.Switch_select); end
    n_cmp++; if (bus.IO_address !== 2'b10) begin n_fail++; $display("FAIL sw_addr1 got %b exp 10", bus.IO_address); end
    n_cmp++; if (bus.IO_write_enable !== 1'b0) begin n_fail++; $display("FAIL sw_we1 got %b exp 0", bus.IO_write_enable); end
    step();
    n_cmp++; if (bus.Rdata_out !== 32'h00001234) begin n_fail++; $display("FAIL sw_rdata got %h exp 00001234", bus.Rdata_out); end
    n_cmp++; if (bus.Switch_select !== 1'b0) begin n_fail++; $display("FAIL sw_sel2 got %b exp 0", bus.Switch_select); end
    n_cmp++; if (bus.Bus_error !== 1'b0) begin n_fail++; $display("FAIL sw_err got %b exp 0", bus.Bus_error); end
    step();
    idle_in();
  endtask

  task automatic test_illegal;
    drive(32'hFFFFFC60, 1'b1, 1'b0, 32'h0, 32'h55555555, 16'hFFFF);
    step();
    n_cmp++; if ({bus.LED_select, bus.Switch_select, bus.IO_write_enable} !== 3'b000) begin n_fail++; $display("FAIL ill1_sel got %b exp 000", {bus.LED_select, bus.Switch_select, bus.IO_write_enable}); end
    step();
    n_cmp++; if (bus.Rdata_out !== 32'h0) begin n_fail++; $display("FAIL ill1_rdata got %h exp 0", bus.Rdata_out); end
    n_cmp++; if (bus.Bus_error !== 1'b1) begin n_fail++; $display("FAIL ill1_err got %b exp 1", bus.Bus_error); end
    n_cmp++; if (bus.Err_addr !== 32'hFFFFFC60) begin n_fail++; $display("FAIL ill1_eaddr got %h exp fffffc60", bus.Err_addr); end
    step();
    drive(32'hFFFFFC64, 1'b0, 1'b1, 32'h0000BEEF, 32'h0, 16'h0);
    step();
    n_cmp++; if ({bus.LED_select, bus.Switch_select, bus.IO_write_enable} !== 3'b000) begin n_fail++; $display("FAIL ill2_sel got %b exp 000", {bus.LED_select, bus.Switch_select, bus.IO_write_enable}); end
    step();
    n_cmp++; if (bus.Bus_error !== 1'b1) begin n_fail++; $display("FAIL ill2_err got %b exp 1", bus.Bus_error); end
    n_cmp++; if (bus.Err_addr !== 32'hFFFFFC60) begin n_fail++; $display("FAIL ill2_eaddr got %h exp fffffc60", bus.Err_addr); end
    step();
    idle_in();
  endtask

  task automatic test_ram;
    drive(32'h00000100, 1'b0, 1'b1, 32'h12345678, 32'hCAFEF00D, 16'h0);
    n_cmp++; if (bus.Mem_we !== 1'b1) begin n_fail++; $display("FAIL ram_mwe got %b exp 1", bus.Mem_we); end
    n_cmp++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL ram_stall got %b exp 0", bus.Stall); end
    n_cmp++; if (bus.Rdata_out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ram_rdata got %h exp cafef00d", bus.Rdata_out); end
    step();
    n_cmp++; if ({bus.LED_select, bus.Switch_select, bus.IO_write_enable, bus.IO_address, bus.IO_wdata} !== 21'h0) begin n_fail++; $display("FAIL ram_io got %h exp 0", {bus.LED_select, bus.Switch_select, bus.IO_write_enable, bus.IO_address, bus.IO_wdata}); end
    idle_in();
  endtask

  task automatic test_back_to_back;
    logic       led[8];
    logic       stl[8];
    logic [15:0] wd[8];
    for (int c = 0; c < 8; c++) begin
      if (c < 3)      drive(32'hFFFFFC60, 1'b0, 1'b1, 32'h00001111, 32'h0, 16'h0);
      else if (c < 6) drive(32'hFFFFFC62, 1'b0, 1'b1, 32'h00002222, 32'h0, 16'h0);
      else            idle_in();
      led[c] = bus.LED_select;
      stl[c] = bus.Stall;
      wd[c]  = bus.IO_wdata;
      step();
    end
    for (int c = 0; c < 8; c++) begin
      n_cmp++; if (led[c] !== ((c == 1) || (c == 4))) begin n_fail++; $display("FAIL b2b_sel cycle %0d got %b exp %b", c, led[c], (c == 1) || (c == 4)); end
    end
    n_cmp++; if (stl[2] !== 1'b0 || stl[3] !== 1'b1) begin n_fail++; $display("FAIL b2b_stall got %b%b exp 01", stl[2], stl[3]); end
    n_cmp++; if (wd[1] !== 16'h1111 || wd[4] !== 16'h2222) begin n_fail++; $display("FAIL b2b_wdata got %h/%h exp 1111/2222", wd[1], wd[4]); end
  endtask

  task automatic test_reset_in_access;
    drive(32'hFFFFFC62, 1'b0, 1'b1, 32'h00007777, 32'h0, 16'h0);
    step();
    n_cmp++; if (bus.LED_select !== 1'b1) begin n_fail++; $display("FAIL rac_sel_pre got %b exp 1", bus.LED_select); end
    reset = 1'b0;
    idle_in();
    step();
    n_cmp++; if (bus.LED_select !== 1'b0) begin n_fail++; $display("FAIL rac_sel got %b exp 0", bus.LED_select); end
    n_cmp++; if (bus.IO_write_enable !== 1'b0) begin n_fail++; $display("FAIL rac_we got %b exp 0", bus.IO_write_enable); end
    n_cmp++; if ({bus.Stall, bus.Switch_select, bus.IO_address, bus.IO_wdata, bus.Bus_error, bus.Err_addr, bus.Rdata_out} !== 84'h0) begin n_fail++; $display("FAIL rac_outs got %h exp 0", {bus.Stall, bus.Switch_select, bus.IO_address, bus.IO_wdata, bus.Bus_error, bus.Err_addr, bus.Rdata_out}); end
    reset = 1'b1;
    step();
    // Back in IDLE: a fresh I/O request must stall immediately
    drive(32'hFFFFFC62, 1'b0, 1'b1, 32'h00007777, 32'h0, 16'h0);
    n_cmp++; if (bus.Stall !== 1'b1) begin n_fail++; $display("FAIL rac_idle got %b exp 1", bus.Stall); end
    step(); step(); step();
    idle_in();
  endtask

  task automatic test_random;
    int offs[8] = '{10'h060, 10'h062, 10'h070, 10'h072, 10'h061, 10'h064, 10'h000, 10'h3FF};
    logic [31:0] a, wd, md;
    logic [15:0] sw;
    logic rd, wr;
    int cls;
    m_err   = 1'b0;
    m_eaddr = 32'h0;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom;
        if (a[31:10] == 22'h3FFFFF) a[31] = 1'b0;
      end else begin
        a = 32'hFFFFFC00 + 32'(offs[$urandom_range(0, 7)]);
      end
      {rd, wr} = 2'($urandom_range(0, 3));
      wd  = $urandom;
      md  = $urandom;
      sw  = 16'($urandom);
      cls = classify(a, rd, wr);
      drive(a, rd, wr, wd, md, sw);
      if (cls == 0) begin
        n_cmp++; if ({bus.Stall, bus.Mem_we, bus.Rdata_out} !== {1'b0, wr, md}) begin n_fail++; $display("FAIL rnd_ram it %0d got %h exp %h", k, {bus.Stall, bus.Mem_we, bus.Rdata_out}, {1'b0, wr, md}); end
        step();
      end else begin
        n_cmp++; if ({bus.Stall, bus.Mem_we, bus.LED_select, bus.Switch_select} !== 4'b1000) begin n_fail++; $display("FAIL rnd_c0 it %0d got %b exp 1000", k, {bus.Stall, bus.Mem_we, bus.LED_select, bus.Switch_select}); end
        step();
        sw = 16'($urandom);
        drive(a, rd, wr, wd, md, sw);
        n_cmp++; if ({bus.Stall, bus.LED_select, bus.Switch_select, bus.IO_write_enable} !== {1'b1, cls == 1, cls == 2, cls == 1}) begin n_fail++; $display("FAIL rnd_sel it %0d got %b exp %b", k, {bus.Stall, bus.LED_select, bus.Switch_select, bus.IO_write_enable}, {1'b1, cls == 1, cls == 2, cls == 1}); end
        n_cmp++; if ({bus.IO_address, bus.IO_wdata} !== {a[1:0], wd[15:0]}) begin n_fail++; $display("FAIL rnd_io it %0d got %h exp %h", k, {bus.IO_address, bus.IO_wdata}, {a[1:0], wd[15:0]}); end
        n_cmp++; if (bus.Bus_error !== m_err) begin n_fail++; $display("FAIL rnd_err_early it %0d got %b exp %b", k, bus.Bus_error, m_err); end
        if (cls == 3) begin
          if (!m_err) m_eaddr = a;
          m_err = 1'b1;
        end
        step();
        n_cmp++; if ({bus.Stall, bus.Mem_we, bus.LED_select, bus.Switch_select, bus.IO_write_enable, bus.IO_address, bus.IO_wdata} !== 22'h0) begin n_fail++; $display("FAIL rnd_done it %0d got %h exp 0", k, {bus.Stall, bus.Mem_we, bus.LED_select, bus.Switch_select, bus.IO_write_enable, bus.IO_address, bus.IO_wdata}); end
        n_cmp++; if ({bus.Bus_error, bus.Err_addr} !== {m_err, m_eaddr}) begin n_fail++; $display("FAIL rnd_err it %0d got %h exp %h", k, {bus.Bus_error, bus.Err_addr}, {m_err, m_eaddr}); end
        if (rd) begin
          n_cmp++; if (bus.Rdata_out !== ((cls == 2) ? {16'h0, sw} : 32'h0)) begin n_fail++; $display("FAIL rnd_rdata it %0d got %h exp %h", k, bus.Rdata_out, (cls == 2) ? {16'h0, sw} : 32'h0); end
        end
        step();
      end
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_led_write();
    test_switch_read();
    test_illegal();
    test_ram();
    test_back_to_back();
    test_reset_in_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
